// File: rtl/przesuniecie_pkg.sv
// Shared types for the sequential arithmetic shifter przesuniecie_sekw.
// Sticky bit positions apply when PRZESUNIECIE_STICKY_FLAGS_EN is defined.
package przesuniecie_pkg;

    typedef enum logic [1:0] {
        ASL = 2'b00,
        ASR = 2'b01,
        LSR = 2'b10,
        ROL = 2'b11
    } shift_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam int STICKY_ERR = 0;
    localparam int STICKY_OVF = 1;

endpackage

// File: rtl/przesuniecie_krok.sv
// Combinational single-step shifter: moves value by s (0..STEP) bits in the
// selected mode and reports whether an ASL step dropped significant bits.
module przesuniecie_krok
    import przesuniecie_pkg::*;
#(
    parameter int BITS = 32,
    parameter int STEP = 4
) (
    input  logic [BITS-1:0]             value,
    input  shift_mode_t                 mode,
    input  logic [$clog2(STEP+1)-1:0]   s,
    output logic [BITS-1:0]             result,
    output logic                        step_ovf
);

    logic signed [BITS-1:0] value_s;

    assign value_s = value;

    always_comb begin
        result = value;
        unique case (mode)
            ASL:     result = value << s;
            ASR:     result = value_s >>> s;
            LSR:     result = value >> s;
            ROL:     result = (value << s) | (value >> (BITS - int'(s)));
            default: result = value;
        endcase
    end

    // Any of the s bits below the MSB that differs from it is lost significance.
    always_comb begin
        step_ovf = 1'b0;
        for (int i = 1; i <= STEP; i++) begin
            if ((i <= int'(s)) && (value[BITS-1-i] != value[BITS-1]))
                step_ovf = 1'b1;
        end
        if (mode != ASL)
            step_ovf = 1'b0;
    end

endmodule

// File: rtl/przesuniecie_sekw.sv
// Multi-cycle arithmetic/logical/rotate shifter, STEP bits per clock, with
// valid/ready handshakes. Define PRZESUNIECIE_STICKY_FLAGS_EN for sticky flags.
module przesuniecie_sekw
    import przesuniecie_pkg::*;
#(
    parameter int BITS = 32,
    parameter int STEP = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [1:0]      i_mode,
    input  logic [BITS-1:0] i_arg_A,
    input  logic [BITS-1:0] i_arg_B,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [BITS-1:0] o_result,
    output logic            o_error,
`ifdef PRZESUNIECIE_STICKY_FLAGS_EN
    input  logic            i_sticky_clr,
    output logic [1:0]      o_sticky,
`endif
    output logic            o_overflow
);

    localparam int RW = $clog2(BITS + 1);
    localparam int SW = $clog2(STEP + 1);
    localparam logic [BITS-1:0] LIM    = BITS'(BITS);
    localparam logic [RW-1:0]   STEP_R = RW'(STEP);

    state_t            state, state_nx;
    shift_mode_t       mode_in, mode_r;
    logic [RW-1:0]     rem, rem_nx;
    logic [SW-1:0]     s_cur;
    logic [BITS-1:0]   acc, step_res, rol_mod;
    logic              err_r, ovf_r, step_ovf;
    logic              accept, handoff, b_neg, b_zero, b_big, rol_zero, imm_done;

    assign mode_in  = shift_mode_t'(i_mode);
    assign accept   = o_ready & i_valid;
    assign handoff  = (state == DONE) & i_ready;
    assign b_neg    = i_arg_B[BITS-1];
    assign b_zero   = (i_arg_B == '0);
    assign b_big    = !b_neg && (i_arg_B >= LIM);
    assign rol_mod  = i_arg_B % LIM;
    assign rol_zero = (rol_mod == '0);
    // A large ROL amount only completes at once when it is a whole number of turns.
    assign imm_done = b_neg | b_zero | (b_big & ((mode_in != ROL) | rol_zero));

    assign s_cur  = (rem < STEP_R) ? rem[SW-1:0] : SW'(STEP);
    assign rem_nx = rem - RW'(s_cur);

    przesuniecie_krok #(
        .BITS (BITS),
        .STEP (STEP)
    ) u_krok (
        .value    (acc),
        .mode     (mode_r),
        .s        (s_cur),
        .result   (step_res),
        .step_ovf (step_ovf)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = imm_done ? DONE : SHIFT;
            SHIFT:   if (rem_nx == '0) state_nx = DONE;
            DONE:    if (i_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        o_ready    = (state == IDLE);
        o_valid    = (state == DONE);
        o_result   = acc;
        o_error    = err_r;
        o_overflow = ovf_r;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            acc    <= '0;
            err_r  <= 1'b0;
            ovf_r  <= 1'b0;
            rem    <= '0;
            mode_r <= ASL;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        mode_r <= mode_in;
                        err_r  <= b_neg;
                        ovf_r  <= 1'b0;
                        rem    <= i_arg_B[RW-1:0];
                        acc    <= i_arg_A;
                        if (b_neg) begin
                            acc <= '0;
                        end else if (b_big) begin
                            unique case (mode_in)
                                ASL: begin
                                    acc   <= '0;
                                    ovf_r <= (i_arg_A != '0);
                                end
                                ASR:     acc <= {BITS{i_arg_A[BITS-1]}};
                                LSR:     acc <= '0;
                                ROL:     rem <= rol_mod[RW-1:0];
                                default: acc <= i_arg_A;
                            endcase
                        end
                    end
                end
                SHIFT: begin
                    acc   <= step_res;
                    ovf_r <= ovf_r | step_ovf;
                    rem   <= rem_nx;
                end
                default: ;
            endcase
        end
    end

`ifdef PRZESUNIECIE_STICKY_FLAGS_EN
    // A flag arriving on the hand-off edge survives a simultaneous clear.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_sticky <= 2'b00;
        end else if (handoff) begin
            o_sticky[STICKY_ERR] <= (o_sticky[STICKY_ERR] & ~i_sticky_clr) | err_r;
            o_sticky[STICKY_OVF] <= (o_sticky[STICKY_OVF] & ~i_sticky_clr) | ovf_r;
        end else if (i_sticky_clr) begin
            o_sticky <= 2'b00;
        end
    end
`else
    logic unused_handoff;
    assign unused_handoff = handoff;
`endif

endmodule

// File: tb/tb_przesuniecie_sekw.sv
// Directed-vector bench for przesuniecie_sekw (BITS=32, STEP=4); sticky-flag
// vectors are added when PRZESUNIECIE_STICKY_FLAGS_EN is defined.
module tb_przesuniecie_sekw;

    localparam logic [1:0] M_ASL = 2'b00;
    localparam logic [1:0] M_ASR = 2'b01;
    localparam logic [1:0] M_LSR = 2'b10;
    localparam logic [1:0] M_ROL = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [1:0]  i_mode = 2'b00;
    logic [31:0] i_arg_A = '0;
    logic [31:0] i_arg_B = '0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [31:0] o_result;
    logic        o_error;
    logic        o_overflow;
`ifdef PRZESUNIECIE_STICKY_FLAGS_EN
    logic        i_sticky_clr = 1'b0;
    logic [1:0]  o_sticky;
    logic        clr_on_handoff = 1'b0;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    przesuniecie_sekw #(
        .BITS (32),
        .STEP (4)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_mode       (i_mode),
        .i_arg_A      (i_arg_A),
        .i_arg_B      (i_arg_B),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_result     (o_result),
        .o_error      (o_error),
`ifdef PRZESUNIECIE_STICKY_FLAGS_EN
        .i_sticky_clr (i_sticky_clr),
        .o_sticky     (o_sticky),
`endif
        .o_overflow   (o_overflow)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // exp_sh counts SHIFT edges between the accept edge and o_valid (0 = immediate).
    task automatic do_op(input string tag, input logic [1:0] m, input logic [31:0] a,
                         input logic [31:0] b, input int exp_sh, input logic [31:0] exp_res,
                         input logic exp_err, input logic exp_ovf, input int hold);
        int sh;
        @(negedge clk);
        chk({tag, ".rdy_in"}, {31'b0, o_ready}, 32'd1);
        i_valid = 1'b1;
        i_mode  = m;
        i_arg_A = a;
        i_arg_B = b;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_mode  = M_ROL;
        i_arg_A = 32'hDEADBEEF;
        i_arg_B = 32'd3;
        sh = 0;
        while (!o_valid && sh < 40) begin
            @(posedge clk);
            #1;
            sh++;
        end
        chk({tag, ".lat"}, sh, exp_sh);
        chk({tag, ".res"}, o_result, exp_res);
        chk({tag, ".err"}, {31'b0, o_error}, {31'b0, exp_err});
        chk({tag, ".ovf"}, {31'b0, o_overflow}, {31'b0, exp_ovf});
        chk({tag, ".rdy_busy"}, {31'b0, o_ready}, 32'd0);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            #1;
            chk({tag, ".hold_vld"}, {31'b0, o_valid}, 32'd1);
            chk({tag, ".hold_res"}, o_result, exp_res);
            chk({tag, ".hold_flg"}, {30'b0, o_error, o_overflow}, {30'b0, exp_err, exp_ovf});
            chk({tag, ".hold_rdy"}, {31'b0, o_ready}, 32'd0);
        end
        @(negedge clk);
        i_ready = 1'b1;
`ifdef PRZESUNIECIE_STICKY_FLAGS_EN
        i_sticky_clr = clr_on_handoff;
`endif
        @(posedge clk);
        #1;
        i_ready = 1'b0;
`ifdef PRZESUNIECIE_STICKY_FLAGS_EN
        i_sticky_clr = 1'b0;
`endif
        chk({tag, ".vld_after"}, {31'b0, o_valid}, 32'd0);
        chk({tag, ".rdy_after"}, {31'b0, o_ready}, 32'd1);
        chk({tag, ".res_after"}, o_result, exp_res);
    endtask

    initial begin
        #1;
        rst = 1'b1;
        #2;
        chk("rst.vld", {31'b0, o_valid}, 32'd0);
        chk("rst.res", o_result, 32'd0);
        chk("rst.flg", {30'b0, o_error, o_overflow}, 32'd0);
        chk("rst.rdy", {31'b0, o_ready}, 32'd1);
`ifdef PRZESUNIECIE_STICKY_FLAGS_EN
        chk("rst.sticky", {30'b0, o_sticky}, 32'd0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        do_op("asl_3_5",     M_ASL, 32'h00000003, 32'd5,        2, 32'h00000060, 1'b0, 1'b0, 0);
        do_op("asr_neg_4",   M_ASR, 32'h80000000, 32'd4,        1, 32'hF8000000, 1'b0, 1'b0, 0);
        do_op("lsr_40",      M_LSR, 32'h80000000, 32'd40,       0, 32'h00000000, 1'b0, 1'b0, 0);
        do_op("asl_ovf_1",   M_ASL, 32'h40000000, 32'd1,        1, 32'h80000000, 1'b0, 1'b1, 0);
        do_op("asl_32",      M_ASL, 32'h00000001, 32'd32,       0, 32'h00000000, 1'b0, 1'b1, 0);
        do_op("lsr_negb",    M_LSR, 32'h00001234, 32'hFFFFFFFF, 0, 32'h00000000, 1'b1, 1'b0, 0);
        do_op("rol_33",      M_ROL, 32'h80000001, 32'd33,       1, 32'h00000003, 1'b0, 1'b0, 0);
        do_op("asr_31_bp",   M_ASR, 32'hFFFF0000, 32'd31,       8, 32'hFFFFFFFF, 1'b0, 1'b0, 5);
        do_op("asl_b0",      M_ASL, 32'h12345678, 32'd0,        0, 32'h12345678, 1'b0, 1'b0, 0);
        do_op("asr_pos_35",  M_ASR, 32'h7FFFFFFF, 32'd35,       0, 32'h00000000, 1'b0, 1'b0, 0);
        do_op("rol_64",      M_ROL, 32'h12345678, 32'd64,       0, 32'h12345678, 1'b0, 1'b0, 0);
        do_op("rol_8",       M_ROL, 32'h12345678, 32'd8,        2, 32'h34567812, 1'b0, 1'b0, 0);
        do_op("lsr_6",       M_LSR, 32'hF0000000, 32'd6,        2, 32'h03C00000, 1'b0, 1'b0, 0);
        do_op("asl_ovf_4",   M_ASL, 32'h08000000, 32'd4,        1, 32'h80000000, 1'b0, 1'b1, 0);
        do_op("asl_m1_31",   M_ASL, 32'hFFFFFFFF, 32'd31,       8, 32'h80000000, 1'b0, 1'b0, 0);

        // Asynchronous reset on the third SHIFT cycle of a 5-step ASL.
        @(negedge clk);
        i_valid = 1'b1;
        i_mode  = M_ASL;
        i_arg_A = 32'h00000001;
        i_arg_B = 32'd20;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("mid.acc", o_result, 32'h00000100);
        #2;
        rst = 1'b1;
        #1;
        chk("mid.vld", {31'b0, o_valid}, 32'd0);
        chk("mid.res", o_result, 32'd0);
        chk("mid.rdy", {31'b0, o_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        do_op("post_rst", M_ROL, 32'h80000001, 32'd33, 1, 32'h00000003, 1'b0, 1'b0, 0);

`ifdef PRZESUNIECIE_STICKY_FLAGS_EN
        do_op("stk_ovf", M_ASL, 32'h40000000, 32'd1, 1, 32'h80000000, 1'b0, 1'b1, 0);
        chk("stk.ovf", {30'b0, o_sticky}, 32'd2);
        clr_on_handoff = 1'b1;
        do_op("stk_err", M_ASR, 32'h00000055, 32'h80000000, 0, 32'h00000000, 1'b1, 1'b0, 0);
        clr_on_handoff = 1'b0;
        chk("stk.clr_set", {30'b0, o_sticky}, 32'd1);
        @(negedge clk);
        i_sticky_clr = 1'b1;
        @(negedge clk);
        i_sticky_clr = 1'b0;
        chk("stk.clr", {30'b0, o_sticky}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
